// File: rtl/tc_countdown_pkg.sv
// Shared types and sizing helpers for the TC countdown timer.
// Optional feature macro: TC_COUNTDOWN_PRESCALER_EN (tick divider in front of the counter).
package tc_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } tc_cd_state_t;

    // Default prescale ratio and the counter width it needs.
    localparam int TC_CD_PRESCALE_DEF = 4;
    localparam int TC_CD_PS_W         = $clog2(TC_CD_PRESCALE_DEF);

    // Prescaler counter width for an arbitrary ratio; never narrower than one bit.
    function automatic int tc_ps_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tc_prescaler.sv
// Tick divider: one-cycle tick every 'prescale' enabled clocks.
// Only instantiated when TC_COUNTDOWN_PRESCALER_EN is defined.
module tc_prescaler
    import tc_countdown_pkg::*;
#(
    parameter int prescale = TC_CD_PRESCALE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              PS_W = tc_ps_width(prescale);
    localparam logic [PS_W-1:0] LAST = PS_W'(prescale - 1);

    logic [PS_W-1:0] r_cnt;

    // Count enabled clocks, wrapping at the last slot; clr restarts the phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PS_W'(1);
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/tc_countdown_timer.sv
// Down-counting timer with one-shot or auto-reload operation.
// Optional feature macro: TC_COUNTDOWN_PRESCALER_EN -- when defined, the counter
// decrements once every 'prescale' clocks in RUN instead of every clock.
module tc_countdown_timer
    import tc_countdown_pkg::*;
#(
    parameter int size     = 8,
    parameter int prescale = TC_CD_PRESCALE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [size-1:0] in,
    input  logic            start,
    input  logic            stop,
    input  logic            reload_en,
    output logic [size-1:0] out,
    output logic            busy,
    output logic            done
);

    // Reject prescale ratios outside the supported range at elaboration.
    if (prescale < 2 || prescale > 65536) begin : g_bad_prescale
        $error("tc_countdown_timer: prescale must be in 2..65536");
    end

    tc_cd_state_t    r_state;
    tc_cd_state_t    w_state_nxt;
    logic [size-1:0] r_out;
    logic [size-1:0] w_out_nxt;
    logic [size-1:0] r_reload;
    logic [size-1:0] w_reload_nxt;
    logic            r_busy;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_start_ok;
    logic            w_ps_clr;
    logic            w_tick;

    // start only wins when nothing of higher priority is present and there is something to count.
    assign w_start_ok = !load && !stop && start && (r_state != ST_RUN) && (r_out != '0);
    assign w_ps_clr   = load || stop || w_start_ok;

`ifdef TC_COUNTDOWN_PRESCALER_EN
    tc_prescaler #(
        .prescale (prescale)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_ps_clr),
        .en   (r_state == ST_RUN),
        .tick (w_tick)
    );
`else
    // Without the divider every RUN clock is a tick; w_ps_clr has no consumer.
    assign w_tick = (r_state == ST_RUN) && !w_ps_clr;
`endif

    // Next-state, next-count and expiry decode in priority order load > stop > start > tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;
        if (load) begin
            w_out_nxt    = in;
            w_reload_nxt = in;
            w_state_nxt  = ST_IDLE;
        end else if (stop) begin
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_HOLD;
            end
        end else if (w_start_ok) begin
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_RUN && w_tick) begin
            if (r_out > size'(1)) begin
                w_out_nxt = r_out - size'(1);
            end else begin
                // Expiry: reload only when periodic mode has a non-zero period to reload.
                w_done_nxt = 1'b1;
                if (reload_en && (r_reload != '0)) begin
                    w_out_nxt = r_reload;
                end else begin
                    w_out_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    // State, count, reload value and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_out    <= '0;
            r_reload <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_reload <= w_reload_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= w_done_nxt;
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_tc_countdown_timer.sv
// Bench for tc_countdown_timer: abstract reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tc_countdown_timer;

    localparam int SIZE = 8;
`ifdef TC_COUNTDOWN_PRESCALER_EN
    localparam int PRESC = 4;
`else
    localparam int PRESC = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            load = 1'b0;
    logic [SIZE-1:0] tb_in = '0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            reload_en = 1'b0;
    logic [SIZE-1:0] out;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;

    tc_countdown_timer #(
        .size     (SIZE),
        .prescale (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .in        (tb_in),
        .start     (start),
        .stop      (stop),
        .reload_en (reload_en),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a count that is either running or not, plus the period to reload.
    logic [SIZE-1:0] m_out = '0;
    logic [SIZE-1:0] m_rel = '0;
    bit              m_run = 0;
    bit              m_done = 0;
    int              m_clk = 0;   // RUN clocks since the current tick period began

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out = 0; m_rel = 0; m_run = 0; m_done = 0; m_clk = 0;
        end else begin
            m_done = 0;
            if (load) begin
                m_out = tb_in; m_rel = tb_in; m_run = 0; m_clk = 0;
            end else if (stop) begin
                m_run = 0; m_clk = 0;
            end else if (start && !m_run && m_out != 0) begin
                m_run = 1; m_clk = 0;
            end else if (m_run) begin
                m_clk = m_clk + 1;
                if (m_clk == PRESC) begin
                    m_clk = 0;
                    if (m_out > 1) begin
                        m_out = m_out - 1;
                    end else begin
                        m_done = 1;
                        if (reload_en && m_rel != 0) m_out = m_rel;
                        else begin m_out = 0; m_run = 0; end
                    end
                end
            end
        end
    end

    // Every cycle out of reset, the DUT must agree with the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("model_out", out, m_out);
            chk("model_busy", busy, m_run);
            chk("model_done", done, m_done);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq4[12];
        // Reset state
        step(); step();
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        step();

`ifndef TC_COUNTDOWN_PRESCALER_EN
        // One-shot countdown from 3
        load = 1; tb_in = 3; step();
        load = 0; start = 1; step();
        start = 0;
        chk("os_entry_out", out, 3); chk("os_entry_busy", busy, 1);
        step(); chk("os_out2", out, 2); chk("os_done2", done, 0);
        step(); chk("os_out1", out, 1);
        step(); chk("os_out0", out, 0); chk("os_done0", done, 1); chk("os_busy0", busy, 0);
        step(); chk("os_done_clear", done, 0); chk("os_out_stay", out, 0);

        // Periodic countdown from 4
        seq4 = '{3, 2, 1, 4, 3, 2, 1, 4, 3, 2, 1, 4};
        load = 1; tb_in = 4; reload_en = 1; step();
        load = 0; start = 1; step();
        start = 0;
        chk("per_entry_out", out, 4);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("per_out", out, seq4[i]);
            chk("per_done", done, (seq4[i] == 4) ? 1 : 0);
            chk("per_busy", busy, 1);
        end

        // Pause and resume
        reload_en = 0;
        load = 1; tb_in = 10; step();
        load = 0; start = 1; step();
        start = 0;
        step(); step(); step();
        chk("pr_before_stop", out, 7);
        stop = 1; step(); stop = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pr_hold_out", out, 7);
            chk("pr_hold_busy", busy, 0);
        end
        start = 1; step(); start = 0;
        chk("pr_resume_busy", busy, 1); chk("pr_resume_out", out, 7);
        step(); chk("pr_out6", out, 6);
        step(); chk("pr_out5", out, 5);

        // Priority: load beats stop and start in RUN
        load = 1; stop = 1; start = 1; tb_in = 9; step();
        load = 0; stop = 0; start = 0;
        chk("pri_out", out, 9); chk("pri_busy", busy, 0);
        step(); chk("pri_idle_out", out, 9); chk("pri_idle_busy", busy, 0);
        load = 1; tb_in = 0; step(); load = 0;
        start = 1; step(); start = 0;
        chk("zero_start_busy", busy, 0); chk("zero_start_out", out, 0);
        step(); chk("zero_start_done", done, 0);
`else
        // Prescaled countdown from 2 with a 4-clock tick
        load = 1; tb_in = 2; step();
        load = 0; start = 1; step();
        start = 0;
        chk("ps_entry_out", out, 2);
        step(); step(); step();
        chk("ps_out2_late", out, 2);
        step(); chk("ps_out1", out, 1); chk("ps_done1", done, 0);
        step(); step(); step();
        chk("ps_out1_late", out, 1); chk("ps_busy1", busy, 1);
        step(); chk("ps_out0", out, 0); chk("ps_done0", done, 1); chk("ps_busy0", busy, 0);
        step(); chk("ps_done_clear", done, 0);
`endif

        // Asynchronous reset in the middle of a run from 0x37
        load = 1; tb_in = 8'h37; step();
        load = 0; start = 1; step(); start = 0;
        step(); step();
        chk("ar_running", busy, 1);
        rst = 1'b0;
        #1;
        chk("ar_out", out, 0); chk("ar_busy", busy, 0); chk("ar_done", done, 0);
        step();
        rst = 1'b1;
        step(); step();
        chk("ar_idle_out", out, 0); chk("ar_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
